// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, byte-FSM state type and baud helper for the quad-word UART receiver
package uart_pkg;
  localparam int FRAME_BYTES = 8;
  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;
  localparam int IDX_W = $clog2(FRAME_BYTES);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_e;
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction
endpackage

// File: rtl/uart_frame_rx_if.sv
// uart_frame_rx_if: serial line in, packed frame words and status pulses out
//   slave  (receiver): rx in; q0..q3, valid, frame_err, busy out
//   master (line/env): rx out; q0..q3, valid, frame_err, busy in
interface uart_frame_rx_if;
  import uart_pkg::*;
  logic rx;
  logic [WORD_W-1:0] q0, q1, q2, q3;
  logic valid, frame_err, busy;
  modport slave (input rx, output q0, q1, q2, q3, valid, frame_err, busy);
  modport master (output rx, input q0, q1, q2, q3, valid, frame_err, busy);
endinterface

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 2-flop rx synchroniser plus 8N1 byte FSM with mid-bit sampling
//   clk, rst     : clock, asynchronous active-high reset
//   rx           : raw serial line, idle high
//   byte_valid   : one-cycle pulse, one cycle after a good stop sample
//   byte_data    : received byte, stable while byte_valid is high
//   stop_err     : one-cycle pulse, one cycle after a low stop sample
//   start_det    : combinational, high on the edge that leaves IDLE
//   false_start  : combinational, high on the edge a start bit is rejected
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              byte_valid,
  output logic [BYTE_W-1:0] byte_data,
  output logic              stop_err,
  output logic              start_det,
  output logic              false_start
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  rx_state_e state_q, state_d;
  logic [1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic byte_valid_q, byte_valid_d, stop_err_q, stop_err_d;
  logic rx_s, tick;
  assign rx_s = sync_q[1];
  assign byte_valid = byte_valid_q;
  assign byte_data = shift_q;
  assign stop_err = stop_err_q;
  always_comb begin
    sync_d = {sync_q[0], rx};
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    shift_d = shift_q;
    byte_valid_d = 1'b0;
    stop_err_d = 1'b0;
    start_det = 1'b0;
    false_start = 1'b0;
    // START waits half a bit to reach mid-bit; every later sample is a full bit on
    tick = cnt_q == (state_q == START ? HALF_M1 : FULL_M1);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
          start_det = 1'b1;
        end
      end
      START: if (tick) begin
        cnt_d = '0;
        bit_d = '0;
        false_start = rx_s;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (tick) begin
        cnt_d = '0;
        shift_d = {rx_s, shift_q[BYTE_W-1:1]};
        bit_d = bit_q + 1'b1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (tick) begin
        cnt_d = '0;
        byte_valid_d = rx_s;
        stop_err_d = !rx_s;
        state_d = rx_s ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        // a held-low line (break) must not look like a new start bit
        cnt_d = '0;
        state_d = rx_s ? IDLE : WAIT_HIGH;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      sync_q <= 2'b11;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      byte_valid_q <= 1'b0;
      stop_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      byte_valid_q <= byte_valid_d;
      stop_err_q <= stop_err_d;
    end
endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: receives 8N1 bytes and packs each group of 8 into four little-endian 16-bit words
//   clk, rst : clock, asynchronous active-high reset
//   bus      : uart_frame_rx_if.slave -- rx in; q0..q3 (last frame), valid (1-cycle),
//              frame_err (1-cycle, bad stop bit), busy (partial frame pending) out
//   Build option RX_TIMEOUT_EN: an idle gap of TIMEOUT_BITS bit times discards a partial frame.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE),
  parameter int TIMEOUT_BITS = 20
) (
  input logic clk,
  input logic rst,
  uart_frame_rx_if.slave bus
);
  localparam int FW = FRAME_BYTES * BYTE_W;
  logic byte_valid, stop_err, start_det, false_start, timeout, complete;
  logic [BYTE_W-1:0] byte_data;
  logic [FRAME_BYTES-1:0][BYTE_W-1:0] bytes_q, bytes_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic valid_q, valid_d, frame_err_q, frame_err_d, busy_q, busy_d;
  if (CLKS_PER_BIT < 4 || TIMEOUT_BITS < 1) begin : g_bad_cfg
    $error("uart_frame_rx: CLKS_PER_BIT must be >= 4 and TIMEOUT_BITS >= 1");
  end
  uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk(clk),
    .rst(rst),
    .rx(bus.rx),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .stop_err(stop_err),
    .start_det(start_det),
    .false_start(false_start)
  );
`ifdef RX_TIMEOUT_EN
  localparam int TO_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int GW = $clog2(TO_CLKS + 1);
  logic [GW-1:0] gap_q, gap_d;
  logic in_byte_q, in_byte_d;
  always_comb begin
    // in_byte tracks a byte in flight, so the gap only counts between bytes
    in_byte_d = start_det ? 1'b1 : (byte_valid || stop_err || false_start) ? 1'b0 : in_byte_q;
    timeout = !start_det && !in_byte_q && idx_q != '0 && gap_q == GW'(TO_CLKS - 1);
    gap_d = (start_det || timeout || in_byte_q || idx_q == '0) ? '0 : gap_q + 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      gap_q <= '0;
      in_byte_q <= 1'b0;
    end else begin
      gap_q <= gap_d;
      in_byte_q <= in_byte_d;
    end
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    complete = byte_valid && idx_q == IDX_W'(FRAME_BYTES - 1);
    bytes_d = bytes_q;
    if (byte_valid) bytes_d[idx_q] = byte_data;
    // byte 0 sits in the low bits, so the byte array is already {q3,q2,q1,q0}
    frame_d = complete ? bytes_d : frame_q;
    idx_d = (stop_err || timeout) ? '0 : byte_valid ? idx_q + 1'b1 : idx_q;
    valid_d = complete;
    frame_err_d = stop_err;
    // a start in the same cycle as completion begins the next frame, so it wins
    busy_d = start_det ? 1'b1
           : (complete || stop_err || timeout || (false_start && idx_q == '0)) ? 1'b0
           : busy_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bytes_q <= '0;
      frame_q <= '0;
      idx_q <= '0;
      valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      bytes_q <= bytes_d;
      frame_q <= frame_d;
      idx_q <= idx_d;
      valid_q <= valid_d;
      frame_err_q <= frame_err_d;
      busy_q <= busy_d;
    end
  assign bus.q0 = frame_q[WORD_W-1:0];
  assign bus.q1 = frame_q[2*WORD_W-1:WORD_W];
  assign bus.q2 = frame_q[3*WORD_W-1:2*WORD_W];
  assign bus.q3 = frame_q[4*WORD_W-1:3*WORD_W];
  assign bus.valid = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy = busy_q;
endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
- Receive side of the quad-word UART link.
- Deserialises 8N1 bytes from the rx line and packs each group of 8 bytes into four 16-bit words, q0..q3.
- Byte order is little-endian per word: q0[7:0] first, q3[15:8] last.
- Delivers each completed frame with a one-cycle valid pulse to the downstream capture/display logic.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (434), clocks per bit time C; must be >= 4.
- TIMEOUT_BITS, 20, inter-byte gap in bit times that aborts a partial frame (used only with RX_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial line; idle high; asynchronous to clk.
- q0, q1, q2, q3  out  16 each  last completed frame, held until the next completed frame.
- valid  out  1  one-cycle pulse when q0..q3 update.
- frame_err  out  1  one-cycle pulse on a bad stop bit.
- busy  out  1  high while a frame is partially received.

Behaviour:
- Reset values:
  - q0..q3 = 0; valid, frame_err, busy = 0.
  - Both synchroniser flops = 1.
  - Byte FSM in IDLE; byte_index = 0.
- rx passes through a 2-flop synchroniser (rx_s). All timing below is relative to T0, the first clk edge at which rx_s == 0 while in IDLE.
- Let H = CLKS_PER_BIT/2 (integer division) and C = CLKS_PER_BIT.
- Byte FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE -> START at T0; bit counter cleared.
  - START: sample rx_s at T0+H.
    - rx_s == 1 is a false start: go to IDLE; no output, no error.
    - rx_s == 0: go to DATA.
  - DATA: sample bit k (k = 0..7, LSB first) at T0+H+(k+1)*C. After bit 7 go to STOP.
  - STOP: sample at T0+H+9C.
    - rx_s == 1: byte accepted; go to IDLE.
    - rx_s == 0: framing error; go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s == 1, then go to IDLE. This prevents a break condition from retriggering.
- Assembler:
  - An accepted byte is written to bytes[byte_index], one cycle after the stop sample.
  - byte_index then increments. After index 7 it wraps to 0.
- Frame completion, on the same cycle the 8th byte is written:
  - q0 = {b1,b0}, q1 = {b3,b2}, q2 = {b5,b4}, q3 = {b7,b6}, all updated together.
  - valid = 1 for exactly one cycle.
- Framing error:
  - frame_err pulses for one cycle, one cycle after the stop sample.
  - byte_index resets to 0 and the partial frame is discarded.
  - q0..q3 are unchanged and valid is not asserted.
- busy:
  - Set at T0 of the first byte of a frame.
  - Cleared in the cycle valid pulses, on a framing error, or on a timeout.
  - A false start on byte 0 also clears busy.
- A false start on bytes 1..7 leaves byte_index and busy unchanged.
- Back-to-back bytes and frames with zero gap beyond the stop bit are fully supported. A start edge is detected in the cycle immediately after STOP -> IDLE.
- Asynchronous reset mid-byte or mid-frame clears all state immediately. The first falling edge after release starts a new byte.

Optional Feature:
- Macro: RX_TIMEOUT_EN.
- Defined:
  - A gap counter runs while byte_index != 0 and the FSM is in IDLE. It is cleared on any start detection.
  - Reaching TIMEOUT_BITS*C clocks sets byte_index = 0 and busy = 0.
  - frame_err is not asserted on a timeout.
- Undefined:
  - There is no gap counter. A partial frame waits indefinitely and resumes with the next byte.

Decomposition:
- Package uart_pkg holds:
  - FRAME_BYTES = 8, WORD_W = 16, BYTE_W = 8.
  - The byte-FSM state enum (IDLE, START, DATA, STOP, WAIT_HIGH).
  - A function computing CLKS_PER_BIT from CLK_FREQ and BAUD_RATE.
- Sub-module uart_byte_rx contains the synchroniser, the byte FSM and the bit counter.
  - Outputs: byte_valid, byte_data[7:0], stop_err, start_det, false_start.
- uart_frame_rx contains the assembler, the timeout and the output registers.

Test Plan:
All tests run with CLK_FREQ=1000000 and BAUD_RATE=100000, giving C=10.
- Clean frame: send bytes 34 12 78 56 BC 9A F0 DE.
  - Expect q0=1234, q1=5678, q2=9ABC, q3=DEF0.
  - Expect valid high exactly 1 cycle, frame_err never high, busy low after valid.
- Glitch: drive rx low for 3 clk in idle.
  - Expect no byte accepted, busy=0, q unchanged.
- Stop error: on byte 3 of a frame, drive stop bit = 0.
  - Expect frame_err 1-cycle pulse, busy=0, q unchanged.
  - Then send a full frame of 01..08; expect q0=0201, q1=0403, q2=0605, q3=0807, one valid pulse.
- Back-to-back: two frames with no idle gap.
  - Expect two valid pulses 80*C clocks apart, each carrying its own data.
- Timeout: send 4 bytes AA, idle for 25 bit times, then send a full frame 01..08.
  - With RX_TIMEOUT_EN: expect exactly one valid, q0=0201.
  - Without RX_TIMEOUT_EN: expect valid after the 4th new byte, with q0=AAAA, q1=AAAA, q2=0201, q3=0403.
- Reset: assert rst during bit 4 of byte 5.
  - Expect all outputs 0 immediately.
  - A subsequent clean frame is received correctly with one valid pulse.
